seg_scan_capture: RTL
=====================

// Module: seg_scan_capture
// PURPOSE
//   Reads a 2-digit multiplexed, active-low seven-segment bus (seg_cat/seg_an) and recovers
//   the 8-bit hex value being displayed. It is the receiving end of the display-driver
//   interface. It sits in the board test harness, where it self-checks displayed adder sums
//   and lets sums be captured back into logic without a logic analyser.
// PARAMETERS
//   STABLE_CNT  4   consecutive identical clk samples of {seg_an,seg_cat} before a digit is accepted (>=2)
// PORTS
//   clk        in   1  system clock; all logic on posedge
//   rst_n      in   1  synchronous, active-low reset
//   seg_cat    in   7  cathodes {g,f,e,d,c,b,a}; 0 = segment lit
//   seg_an     in   2  anodes, active-low; 2'b10 = low digit, 2'b01 = high digit
//   value      out  8  last published byte {hi_nibble, lo_nibble}
//   valid      out  1  1-cycle pulse when value is (re)published
//   changed    out  1  1-cycle pulse, coincident with valid, when new value != previous published value
//   err        out  1  1-cycle pulse on a stable but illegal pattern or anode code
// BEHAVIOUR
//   Reset (rst_n=0 at posedge): value=8'h00, valid=0, changed=0, err=0, state=S_LO,
//     stab_cnt=0, accepted=0, lo_nib=0, have_prev=0. Reset overrides all other activity,
//     including any partial frame.
//   Sampling: {seg_an,seg_cat} is registered once per clk (1 sample stage), then compared with
//     the previous sample. If equal, stab_cnt increments, saturating at STABLE_CNT. If different,
//     stab_cnt=1 and accepted=0.
//   Acceptance: when stab_cnt first reaches STABLE_CNT and accepted=0, the dwell is evaluated
//     once, and accepted=1 until the sample changes. A dwell is never evaluated twice.
//   Anode classes:
//     2'b10 = LO digit.
//     2'b01 = HI digit.
//     2'b11 = blank; ignored, no err.
//     2'b00 = illegal; err pulse, no state change.
//   Cathode decode (inverse of the team hex table):
//     40->0  79->1  24->2  30->3  19->4  12->5  02->6  78->7
//     00->8  10->9  08->A  03->B  46->C  21->D  06->E  0E->F
//     Any other pattern on an LO/HI dwell: err pulse, digit discarded, state unchanged.
//   FSM:
//     S_LO: accepted LO digit -> lo_nib=decode, go to S_HI. Accepted HI digit -> ignored
//       (no low half yet).
//     S_HI: accepted HI digit -> publish next cycle, go to S_LO. Accepted LO digit -> lo_nib
//       overwritten, stay in S_HI.
//   Publish: value <= {decode_hi, lo_nib}; valid=1 for one cycle.
//     changed=1 if have_prev=0 or the new value != old value; then have_prev=1.
//   Latency: the HI digit's first pin change to valid is STABLE_CNT+2 clk edges.
//   Simultaneity: err and valid are mutually exclusive, since one dwell is evaluated per cycle.
//     A pin change in the acceptance cycle restarts stabilisation and does not cancel an
//     acceptance already made.
//   Glitches shorter than STABLE_CNT samples are invisible. valid repeats every complete LO->HI
//     scan even when value is unchanged, with changed=0 in that case.
// TESTING
//   1. Reset, then drive LO=8'h24 (2) for 10 clk, then HI=8'h79 (1) for 10 clk
//      -> value=8'h12, valid=1 and changed=1 for exactly one cycle; err stays 0.
//   2. Repeat the same scan for 3 frames -> 3 valid pulses, value=8'h12 each time, changed=0
//      on frames 2 and 3.
//   3. LO=F (0E) then HI=7-segment 7'h7F (blank pattern) on an=01 -> err pulse once, no valid;
//      then a legal HI=A (08) -> value=8'hAF.
//   4. Glitch: during a stable LO=5 dwell, hold seg_cat=00 for STABLE_CNT-1 cycles, then
//      return -> no err, and the low nibble accepted is 5 (accepted once per dwell).
//   5. seg_an=2'b00 for 10 clk -> exactly one err pulse; seg_an=2'b11 for 10 clk -> no err,
//      no valid.
//   6. Assert rst_n=0 for one cycle after LO is accepted, then drive HI=3 -> no valid.
//      A full LO=0/HI=3 scan afterwards -> value=8'h30, changed=1.

Source files
------------

// File: rtl/seg_scan_capture.sv
// Recovers the 8-bit hex value shown on a 2-digit multiplexed, active-low
// seven-segment bus by debouncing each anode dwell and decoding the digits.
module seg_scan_capture #(
  parameter int unsigned STABLE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_cat,
  input  logic [1:0] seg_an,
  output logic [7:0] value,
  output logic       valid,
  output logic       changed,
  output logic       err
);

  localparam int unsigned CW = $clog2(STABLE_CNT + 1);

  typedef enum logic {S_LO, S_HI} state_t;

  state_t        state, state_next;
  logic [8:0]    samp, samp_d;
  logic [CW-1:0] stab_cnt;
  logic          accepted;
  logic [3:0]    lo_nib;
  logic          have_prev;
  logic          eval;
  logic          dec_ok;
  logic [3:0]    dec_nib;
  logic          pub, err_next, lo_load;
  logic [7:0]    new_value;

  // Inverse of the hex-to-segment table; unknown patterns flag dec_ok=0.
  always_comb begin
    dec_ok  = 1'b1;
    dec_nib = 4'h0;
    case (samp_d[6:0])
      7'h40: dec_nib = 4'h0;
      7'h79: dec_nib = 4'h1;
      7'h24: dec_nib = 4'h2;
      7'h30: dec_nib = 4'h3;
      7'h19: dec_nib = 4'h4;
      7'h12: dec_nib = 4'h5;
      7'h02: dec_nib = 4'h6;
      7'h78: dec_nib = 4'h7;
      7'h00: dec_nib = 4'h8;
      7'h10: dec_nib = 4'h9;
      7'h08: dec_nib = 4'hA;
      7'h03: dec_nib = 4'hB;
      7'h46: dec_nib = 4'hC;
      7'h21: dec_nib = 4'hD;
      7'h06: dec_nib = 4'hE;
      7'h0E: dec_nib = 4'hF;
      default: dec_ok = 1'b0;
    endcase
  end

  // A dwell is evaluated exactly once, in the cycle after the count saturates.
  assign eval      = (stab_cnt == CW'(STABLE_CNT)) && !accepted;
  assign new_value = {dec_nib, lo_nib};

  always_comb begin
    state_next = state;
    pub        = 1'b0;
    err_next   = 1'b0;
    lo_load    = 1'b0;
    if (eval) begin
      case (samp_d[8:7])
        2'b00: err_next = 1'b1;
        2'b10: begin
          if (!dec_ok) begin
            err_next = 1'b1;
          end else begin
            lo_load    = 1'b1;
            state_next = S_HI;
          end
        end
        2'b01: begin
          if (!dec_ok) begin
            err_next = 1'b1;
          end else if (state == S_HI) begin
            pub        = 1'b1;
            state_next = S_LO;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      samp      <= '1;
      samp_d    <= '1;
      stab_cnt  <= '0;
      accepted  <= 1'b0;
      state     <= S_LO;
      lo_nib    <= '0;
      have_prev <= 1'b0;
      value     <= '0;
      valid     <= 1'b0;
      changed   <= 1'b0;
      err       <= 1'b0;
    end else begin
      samp    <= {seg_an, seg_cat};
      samp_d  <= samp;
      state   <= state_next;
      valid   <= pub;
      err     <= err_next;
      changed <= 1'b0;
      // A pin change in the evaluation cycle still lets that evaluation land.
      if (samp != samp_d) begin
        stab_cnt <= CW'(1);
        accepted <= 1'b0;
      end else begin
        if (stab_cnt != CW'(STABLE_CNT)) stab_cnt <= stab_cnt + CW'(1);
        if (eval) accepted <= 1'b1;
      end
      if (lo_load) lo_nib <= dec_nib;
      if (pub) begin
        value     <= new_value;
        changed   <= !have_prev || (new_value != value);
        have_prev <= 1'b1;
      end
    end
  end

endmodule
